button_debounce_array: RTL and testbench
========================================

// Module: button_debounce_array
// PURPOSE
//   Parametrised, multi-channel successor of the single-button controller. Each channel
//   synchronises a raw button input and debounces it with an internal counter; no external
//   timer is needed. A bounce during either wait window aborts the transition. Per channel it
//   produces a clean level, one-cycle press and release pulses, and a one-cycle long-press
//   pulse. Sits between the board pins and the application FSMs.
// PARAMETERS
//   CHANNELS         4      number of independent button channels (>=1)
//   SYNC_STAGES      2      input synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES  1000   clk cycles the input must be stable to accept an edge (>=1)
//   LONG_CYCLES      50000  clk cycles held in HIGH before long_press fires; 0 disables it
// PORTS
//   clk         in   1         single clock, rising edge
//   reset       in   1         asynchronous, active-low reset
//   in          in   CHANNELS  raw button inputs, asynchronous to clk
//   level       out  CHANNELS  debounced level
//   press       out  CHANNELS  1-cycle pulse on accepted rising edge
//   rel         out  CHANNELS  1-cycle pulse on accepted falling edge
//   long_press  out  CHANNELS  1-cycle pulse, at most once per press
// BEHAVIOUR
//   - reset low: synchronisers, counters, state=LOW, long flag and all outputs cleared to 0
//     immediately, with no clock needed. Release is recognised on the next clk edge.
//   - All outputs are registered. Channels are fully independent and have no shared counter.
//   - s = synchroniser output. cnt width = $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)+1).
//   - FSM per channel:
//     LOW:       level=0. s=1 -> WAIT_HIGH, cnt<=0.
//     WAIT_HIGH: level=0. s=0 -> LOW (abort, no pulse).
//                Else if cnt==DEBOUNCE_CYCLES-1 -> HIGH, press<=1, cnt<=0. Else cnt++.
//     HIGH:      level=1. s=0 -> WAIT_LOW, cnt<=0.
//                Else cnt saturates at LONG_CYCLES. When cnt==LONG_CYCLES-1 and long flag
//                is clear: long_press<=1, flag<=1.
//     WAIT_LOW:  level=1. s=1 -> HIGH (abort, no pulse), cnt<=0, flag kept.
//                If cnt==DEBOUNCE_CYCLES-1 -> LOW, rel<=1, flag<=0. Else cnt++.
//   - Latency: edge 0 is the first clk edge that samples a new stable in value. press or rel
//     is high for exactly the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES, and level
//     changes on that same edge.
//   - long_press is high for the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+LONG_CYCLES.
//     It never re-fires within one press, including after a bounced release.
//   - If a release is accepted before LONG_CYCLES elapse, there is no long_press.
//   - press, rel and long_press are never high together on one channel.
//   - reset asserted mid-wait discards the partial count. No pulse is emitted.
// STRUCTURE
//   - Shared package: state encoding localparams ST_LOW=2'd0, ST_WAIT_HIGH=2'd1, ST_HIGH=2'd2,
//     ST_WAIT_LOW=2'd3, plus a function that computes the counter width.
//   - Sub-module debounce_channel contains the synchroniser, counter, FSM and long flag for one
//     channel. The top level is a generate loop of CHANNELS instances, with no glue logic.
// TESTING  (CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
//   1. in[0] held 1 for 12 cycles, then 0 -> press[0] after edge 6, level[0]=1 from edge 6;
//      rel[0] 6 edges after the first low sample; no long_press.
//   2. in[0] toggles 1,1,1,0,1,1,1,0 (bounce) -> press/level/rel all stay 0.
//   3. in[0] held 1 for 25 cycles -> press after edge 6; exactly one long_press after edge 16.
//   4. In HIGH after a long_press, in[0]=0 for 2 cycles, then 1 -> no rel, level stays 1,
//      no second long_press.
//   5. reset pulled low mid WAIT_HIGH -> outputs 0 with no clk edge; after release, in=1 held
//      -> press 6 edges after the first sampling edge.
//   6. in[0] rises 3 cycles after in[1] -> press[1] and press[0] are each 6 edges after their
//      own rise, 3 cycles apart, with no cross-channel interaction.

Source files
------------

// File: rtl/button_debounce_array_pkg.sv
// Shared definitions for the multi-channel button debouncer: state encoding and
// the counter-width helper used by every channel.
package button_debounce_array_pkg;

    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    typedef enum logic [1:0] {
        S_LOW       = ST_LOW,
        S_WAIT_HIGH = ST_WAIT_HIGH,
        S_HIGH      = ST_HIGH,
        S_WAIT_LOW  = ST_WAIT_LOW
    } state_e;

    // One counter serves both the debounce window and the long-press hold time.
    function automatic int cnt_width(input int debounce_cycles, input int long_cycles);
        int m;
        m = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchroniser, shared debounce/long-press counter,
// four-state FSM and the once-per-press long flag.
//   state       | meaning
//   S_LOW       | released, level=0
//   S_WAIT_HIGH | input seen high, timing debounce window, level=0
//   S_HIGH      | pressed, level=1, counting towards long press
//   S_WAIT_LOW  | input seen low, timing debounce window, level=1
module debounce_channel
    import button_debounce_array_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_press
);

    localparam int            CW        = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);
    localparam bit            LONG_EN   = (LONG_CYCLES > 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   flag_q, flag_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   long_q, long_d;
    logic                   s;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_HIGH;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q < LONG_SAT) cnt_d = cnt_q + 1'b1;
                    // The flag survives bounced releases so long_press fires once per press.
                    if (LONG_EN && (cnt_q == LONG_LAST) && !flag_q) begin
                        long_d = 1'b1;
                        flag_d = 1'b1;
                    end
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_LOW;
                    rel_d   = 1'b1;
                    flag_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_LOW;
        endcase
        level_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign rel        = rel_q;
    assign long_press = long_q;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel button debouncer: CHANNELS independent debounce_channel instances,
// each with its own synchroniser and counter.
module button_debounce_array
    import button_debounce_array_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel,
    output logic [CHANNELS-1:0] long_press
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in        (in[g]),
            .level     (level[g]),
            .press     (press[g]),
            .rel       (rel[g]),
            .long_press(long_press[g])
        );
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Bench for button_debounce_array: timed sequences, a table of press patterns
// with expected pulse counts, and random inputs against a run-length reference model.
module tb_button_debounce_array;

    localparam int N_CH = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LNG  = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] in_r = '0;
    logic [N_CH-1:0] level, press, rel, long_press;

    int n_tests = 0;
    int n_fail  = 0;

    button_debounce_array #(
        .CHANNELS(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)
    ) dut (
        .clk(clk), .reset(reset), .in(in_r),
        .level(level), .press(press), .rel(rel), .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a level flips once the synchronised input has disagreed with it
    // for DEB+1 consecutive samples; the long timer counts undisturbed held-high samples.
    bit              hist [N_CH][SYNC];
    int              run_c [N_CH];
    int              hold_c [N_CH];
    bit              lvl [N_CH];
    bit              flg [N_CH];
    bit              m_s;
    logic [N_CH-1:0] m_level, m_press, m_rel, m_long;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int i = 0; i < SYNC; i++) hist[c][i] = 1'b0;
                run_c[c] = 0; hold_c[c] = 0; lvl[c] = 1'b0; flg[c] = 1'b0;
            end
            m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                m_s = hist[c][SYNC-1];
                for (int i = SYNC - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = in_r[c];
                m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
                if (m_s != lvl[c]) begin
                    run_c[c]++;
                    if (run_c[c] == DEB + 1) begin
                        lvl[c] = m_s; run_c[c] = 0; hold_c[c] = 0;
                        if (m_s) m_press[c] = 1'b1;
                        else begin m_rel[c] = 1'b1; flg[c] = 1'b0; end
                    end
                end else begin
                    if (lvl[c]) begin
                        if (run_c[c] > 0) hold_c[c] = 0;
                        else if (hold_c[c] < LNG) hold_c[c]++;
                        if (LNG > 0 && hold_c[c] == LNG && !flg[c]) begin
                            m_long[c] = 1'b1; flg[c] = 1'b1;
                        end
                    end
                    run_c[c] = 0;
                end
                m_level[c] = lvl[c];
            end
        end
    end

    always @(negedge clk)
        check("model", int'({level, press, rel, long_press}),
              int'({m_level, m_press, m_rel, m_long}));

    // Pulse counters for the table-driven patterns (channel 0), plus channel 1 activity.
    bit cnt_en = 1'b0;
    int cp, cr, cl, c1;
    always @(negedge clk) if (cnt_en) begin
        cp += int'(press[0]); cr += int'(rel[0]); cl += int'(long_press[0]);
        c1 += int'(press[1] | rel[1] | long_press[1]);
    end

    typedef struct { int h1; int gap; int h2; int e_press; int e_rel; int e_long; } vec_t;
    vec_t vecs [12];

    task automatic timed_hold(input string name, input int ch, input int hold, input int n_edges,
                              input int p_edge, input int r_edge, input int l_edge);
        logic [3:0] exp;
        @(negedge clk); in_r[ch] = 1'b1;
        for (int k = 0; k < n_edges; k++) begin
            @(posedge clk); #1;
            exp = {k == p_edge, k == r_edge, k == l_edge, (k >= p_edge) && (k < r_edge)};
            check(name, int'({press[ch], rel[ch], long_press[ch], level[ch]}), int'(exp));
            if (k == hold - 1) begin @(negedge clk); in_r[ch] = 1'b0; end
        end
    endtask

    int rem [N_CH];

    initial begin
        vecs[0]  = '{3, 1, 3, 0, 0, 0};     // bounce 1,1,1,0,1,1,1,0
        vecs[1]  = '{4, 0, 0, 0, 0, 0};     // one sample short of debounce
        vecs[2]  = '{5, 0, 0, 1, 1, 0};     // exactly enough
        vecs[3]  = '{12, 0, 0, 1, 1, 0};
        vecs[4]  = '{14, 0, 0, 1, 1, 0};    // one short of long press
        vecs[5]  = '{15, 0, 0, 1, 1, 1};    // long press boundary
        vecs[6]  = '{25, 0, 0, 1, 1, 1};
        vecs[7]  = '{20, 2, 5, 1, 1, 1};    // bounced release after long press
        vecs[8]  = '{8, 2, 10, 1, 1, 0};    // bounce restarts long timer
        vecs[9]  = '{8, 2, 11, 1, 1, 1};
        vecs[10] = '{5, 4, 5, 1, 1, 0};     // release bounce absorbed
        vecs[11] = '{5, 5, 5, 2, 2, 0};     // real release then re-press

        repeat (2) @(negedge clk);
        check("reset outs", int'({level, press, rel, long_press}), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        timed_hold("t1 hold12", 0, 12, 24, 6, 18, -1);
        repeat (5) @(negedge clk);
        timed_hold("t3 hold25", 0, 25, 36, 6, 31, 16);
        repeat (5) @(negedge clk);

        foreach (vecs[v]) begin
            cp = 0; cr = 0; cl = 0; c1 = 0;
            cnt_en = 1'b1;
            for (int i = 0; i < vecs[v].h1; i++) begin @(negedge clk); in_r[0] = 1'b1; end
            for (int i = 0; i < vecs[v].gap; i++) begin @(negedge clk); in_r[0] = 1'b0; end
            for (int i = 0; i < vecs[v].h2; i++) begin @(negedge clk); in_r[0] = 1'b1; end
            @(negedge clk); in_r[0] = 1'b0;
            repeat (20) @(negedge clk);
            cnt_en = 1'b0;
            check($sformatf("vec%0d press", v), cp, vecs[v].e_press);
            check($sformatf("vec%0d rel", v), cr, vecs[v].e_rel);
            check($sformatf("vec%0d long", v), cl, vecs[v].e_long);
            check($sformatf("vec%0d ch1 quiet", v), c1, 0);
            check($sformatf("vec%0d level", v), int'(level), 0);
        end

        // Two channels with staggered rises and falls.
        @(negedge clk); in_r[1] = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(posedge clk); #1;
            check("t6 press", int'(press), int'({k == 6, k == 9}));
            check("t6 rel", int'(rel), int'({k == 17, k == 20}));
            @(negedge clk);
            if (k == 2)  in_r[0] = 1'b1;
            if (k == 10) in_r[1] = 1'b0;
            if (k == 13) in_r[0] = 1'b0;
        end
        repeat (5) @(negedge clk);

        // Asynchronous reset while channel 1 is HIGH and channel 0 is mid-debounce.
        in_r = 2'b10;
        repeat (10) @(negedge clk);
        check("t5 pre level", int'(level), 2);
        in_r[0] = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("t5 async clear", int'({level, press, rel, long_press}), 0);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("t5 press", int'(press), (k == 6) ? 3 : 0);
            check("t5 level", int'(level), (k >= 6) ? 3 : 0);
        end
        @(negedge clk); in_r = '0;
        repeat (20) @(negedge clk);

        // Random runs: mostly short bounces with occasional long holds.
        foreach (rem[c]) rem[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                if (rem[c] == 0) begin
                    in_r[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                         : int'($urandom_range(1, 6));
                end
                rem[c]--;
            end
        end
        in_r = '0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
